// File: rtl/pedometer_core.sv
// Step-detection engine: accepts multi-axis accelerometer samples, keeps a sliding window
// of per-sample magnitudes and a weight file, scores the window with a saturating MAC and
// counts steps with hysteresis.
module pedometer_core #(
  parameter int DATA_W      = 8,
  parameter int NUM_AXES    = 2,
  parameter int NUM_WEIGHTS = 8,
  parameter int ADDR_W      = $clog2(NUM_WEIGHTS),
  parameter int ACC_W       = 24,
  parameter int CNT_W       = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             sample_valid,
  output logic                             sample_ready,
  input  logic [NUM_AXES*DATA_W-1:0]       sample,
  input  logic                             wr_en1,
  input  logic [ADDR_W-1:0]                wr_addr1,
  input  logic signed [DATA_W-1:0]         wr_data1,
  input  logic                             wr_en2,
  input  logic [ADDR_W-1:0]                wr_addr2,
  input  logic signed [DATA_W-1:0]         wr_data2,
  input  logic signed [ACC_W-1:0]          thr_hi,
  input  logic signed [ACC_W-1:0]          thr_lo,
  input  logic                             clear_count,
  output logic                             step_pulse,
  output logic [CNT_W-1:0]                 step_count,
  output logic                             count_sat,
  output logic                             wr_err,
  output logic signed [ACC_W-1:0]          score
);

  localparam int M_W    = DATA_W + $clog2(NUM_AXES) + 1;
  localparam int PROD_W = DATA_W + M_W + 1;
  localparam int SUM_W  = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, LOAD, MAC, DECIDE} state_t;

  state_t state, state_next;

  logic                       accept;
  logic                       load_en;
  logic                       mac_en;
  logic                       decide_en;
  logic [ADDR_W-1:0]          k;
  logic                       last_k;
  logic [NUM_AXES*DATA_W-1:0] sample_q;
  logic [M_W-1:0]             mag;
  logic [M_W-1:0]             window  [NUM_WEIGHTS];
  logic signed [DATA_W-1:0]   weights [NUM_WEIGHTS];
  logic signed [ACC_W-1:0]    acc;
  logic signed [ACC_W-1:0]    acc_sat;
  logic signed [DATA_W-1:0]   w_k;
  logic [M_W-1:0]             m_k;
  logic signed [PROD_W-1:0]   w_ext;
  logic signed [PROD_W-1:0]   m_ext;
  logic signed [PROD_W-1:0]   prod;
  logic signed [SUM_W-1:0]    sum_ext;
  logic signed [SUM_W-1:0]    acc_max_ext;
  logic signed [SUM_W-1:0]    acc_min_ext;
  logic                       step_hit;
  logic                       rearm;
  logic                       armed;

  function automatic logic [DATA_W:0] abs_val(input logic signed [DATA_W-1:0] a);
    logic signed [DATA_W:0] e;
    e = {a[DATA_W-1], a};
    return (e < 0) ? -e : e;
  endfunction

  // ---------------- control FSM ----------------
  // NOTE: sequential state is written with non-blocking assignments so every register
  // samples pre-edge values, independent of the order the always_ff blocks execute in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  assign last_k = (k == ADDR_W'(NUM_WEIGHTS - 1));

  // NOTE: every combinational output gets a default first, so no path can leave it
  // unassigned and infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = LOAD;
      LOAD:    state_next = MAC;
      MAC:     if (last_k) state_next = DECIDE;
      DECIDE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Ready is gated by reset itself so it stays low for the whole reset pulse.
  always_comb begin
    sample_ready = 1'b0;
    load_en      = 1'b0;
    mac_en       = 1'b0;
    decide_en    = 1'b0;
    case (state)
      IDLE:    sample_ready = ~reset;
      LOAD:    load_en      = 1'b1;
      MAC:     mac_en       = 1'b1;
      DECIDE:  decide_en    = 1'b1;
      default: sample_ready = 1'b0;
    endcase
  end

  assign accept = sample_valid & sample_ready;

  // ---------------- sample capture and window ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       sample_q <= '0;
    else if (accept) sample_q <= sample;
  end

  always_comb begin
    mag = '0;
    for (int i = 0; i < NUM_AXES; i++)
      mag = mag + M_W'(abs_val(sample_q[i*DATA_W +: DATA_W]));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_WEIGHTS; i++) window[i] <= '0;
    end else if (load_en) begin
      window[0] <= mag;
      for (int i = 1; i < NUM_WEIGHTS; i++) window[i] <= window[i-1];
    end
  end

  // ---------------- weight file ----------------
  // NOTE: the weight file is a register array that must read back as zero after reset,
  // so it is cleared in the reset branch rather than left to power-up contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_WEIGHTS; i++) weights[i] <= '0;
      wr_err <= 1'b0;
    end else begin
      wr_err <= (state != IDLE) && (wr_en1 || wr_en2);
      if (state == IDLE) begin
        // Port 2 is assigned last so it wins on an address collision.
        if (wr_en1) weights[wr_addr1] <= wr_data1;
        if (wr_en2) weights[wr_addr2] <= wr_data2;
      end
    end
  end

  // ---------------- saturating MAC ----------------
  assign w_k   = weights[k];
  assign m_k   = window[k];
  assign w_ext = {{(PROD_W-DATA_W){w_k[DATA_W-1]}}, w_k};
  assign m_ext = {{(PROD_W-M_W){1'b0}}, m_k};
  assign prod  = w_ext * m_ext;

  assign sum_ext = {{(SUM_W-PROD_W){prod[PROD_W-1]}}, prod}
                 + {{(SUM_W-ACC_W){acc[ACC_W-1]}}, acc};

  assign acc_max_ext = {{(SUM_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  assign acc_min_ext = {{(SUM_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

  always_comb begin
    acc_sat = sum_ext[ACC_W-1:0];
    if (sum_ext > acc_max_ext)      acc_sat = acc_max_ext[ACC_W-1:0];
    else if (sum_ext < acc_min_ext) acc_sat = acc_min_ext[ACC_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
      k   <= '0;
    end else if (load_en) begin
      acc <= '0;
      k   <= '0;
    end else if (mac_en) begin
      acc <= acc_sat;
      k   <= k + ADDR_W'(1);
    end
  end

  // ---------------- hysteresis decision and counter ----------------
  assign step_hit = decide_en &&  armed && (acc >= thr_hi);
  assign rearm    = decide_en && !armed && (acc <  thr_lo);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      score      <= '0;
      step_pulse <= 1'b0;
      armed      <= 1'b1;
    end else begin
      step_pulse <= step_hit;
      if (decide_en) score <= acc;
      if (step_hit)   armed <= 1'b0;
      else if (rearm) armed <= 1'b1;
    end
  end

  // The counter parks at all-ones; a clear in the same cycle overrides any increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_count <= '0;
      count_sat  <= 1'b0;
    end else if (clear_count) begin
      step_count <= '0;
      count_sat  <= 1'b0;
    end else if (step_hit && (step_count != CNT_MAX)) begin
      step_count <= step_count + CNT_W'(1);
      if (step_count == CNT_MAX - CNT_W'(1)) count_sat <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pedometer_core.sv
// Randomised and directed bench for pedometer_core, checked against a behavioural model
// that scores the window with plain integer arithmetic.
module tb_pedometer_core;

  localparam int DATA_W   = 8;
  localparam int NUM_AXES = 2;
  localparam int NW       = 8;
  localparam int ADDR_W   = 3;
  localparam int ACC_W    = 16;
  localparam int CNT_W    = 4;
  localparam longint ACC_MAX = longint'(2 ** (ACC_W - 1)) - 1;
  localparam longint ACC_MIN = -longint'(2 ** (ACC_W - 1));
  localparam int CNT_MAX  = 2 ** CNT_W - 1;

  logic                         clk = 1'b0;
  logic                         reset;
  logic                         sample_valid;
  logic                         sample_ready;
  logic [NUM_AXES*DATA_W-1:0]   sample;
  logic                         wr_en1;
  logic [ADDR_W-1:0]            wr_addr1;
  logic signed [DATA_W-1:0]     wr_data1;
  logic                         wr_en2;
  logic [ADDR_W-1:0]            wr_addr2;
  logic signed [DATA_W-1:0]     wr_data2;
  logic signed [ACC_W-1:0]      thr_hi;
  logic signed [ACC_W-1:0]      thr_lo;
  logic                         clear_count;
  logic                         step_pulse;
  logic [CNT_W-1:0]             step_count;
  logic                         count_sat;
  logic                         wr_err;
  logic signed [ACC_W-1:0]      score;

  pedometer_core #(
    .DATA_W(DATA_W), .NUM_AXES(NUM_AXES), .NUM_WEIGHTS(NW), .ACC_W(ACC_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .sample(sample),
    .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
    .wr_en2(wr_en2), .wr_addr2(wr_addr2), .wr_data2(wr_data2),
    .thr_hi(thr_hi), .thr_lo(thr_lo), .clear_count(clear_count),
    .step_pulse(step_pulse), .step_count(step_count), .count_sat(count_sat),
    .wr_err(wr_err), .score(score)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  int     m_w   [NW];
  longint m_win [NW];
  bit     m_armed;
  int     m_cnt;
  bit     m_sat;
  int     hi_v;
  int     lo_v;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Window score: sequential accumulation, clamped to the signed range after every term.
  function automatic longint model_score();
    longint a = 0;
    for (int i = 0; i < NW; i++) begin
      a = a + longint'(m_w[i]) * m_win[i];
      if (a > ACC_MAX) a = ACC_MAX;
      if (a < ACC_MIN) a = ACC_MIN;
    end
    return a;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NW; i++) begin
      m_w[i]   = 0;
      m_win[i] = 0;
    end
    m_armed = 1'b1;
    m_cnt   = 0;
    m_sat   = 1'b0;
  endtask

  // ---------------- stimulus helpers (called just after a falling edge) ----------------
  task automatic set_thr(input int h, input int l);
    thr_hi = ACC_W'(h);
    thr_lo = ACC_W'(l);
    hi_v   = h;
    lo_v   = l;
  endtask

  task automatic write_weights(input bit e1, input int a1, input int d1,
                               input bit e2, input int a2, input int d2);
    wr_en1 = e1; wr_addr1 = ADDR_W'(a1); wr_data1 = DATA_W'(d1);
    wr_en2 = e2; wr_addr2 = ADDR_W'(a2); wr_data2 = DATA_W'(d2);
    @(negedge clk);
    wr_en1 = 1'b0;
    wr_en2 = 1'b0;
    if (e1) m_w[a1] = d1;
    if (e2) m_w[a2] = d2;
    check("wr_err_idle", wr_err, 0);
  endtask

  task automatic send_sample(input int ax, input int ay, input bit wr_acc, input int wa,
                             input int wd, input bit bad_wr, input bit clr);
    longint s;
    bit     exp_pulse;
    int     waited = 0;
    while (!sample_ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check("ready_before_sample", sample_ready, 1);
    sample       = {DATA_W'(ay), DATA_W'(ax)};
    sample_valid = 1'b1;
    if (wr_acc) begin
      wr_en2 = 1'b1; wr_addr2 = ADDR_W'(wa); wr_data2 = DATA_W'(wd);
    end
    @(negedge clk);
    sample_valid = 1'b0;
    wr_en2       = 1'b0;
    if (wr_acc) m_w[wa] = wd;
    for (int i = NW - 1; i > 0; i--) m_win[i] = m_win[i-1];
    m_win[0] = iabs(ax) + iabs(ay);

    for (int c = 1; c <= NW + 2; c++) begin
      if (bad_wr && c == 3) begin
        wr_en1 = 1'b1; wr_addr1 = ADDR_W'(wa); wr_data1 = DATA_W'(wd);
      end
      if (bad_wr && c == 4) begin
        check("wr_err_pulse", wr_err, 1);
        wr_en1 = 1'b0;
      end
      if (bad_wr && c == 5) check("wr_err_single", wr_err, 0);
      if (c == NW + 2) begin
        check("pulse_early", step_pulse, 0);
        check("ready_busy", sample_ready, 0);
        clear_count = clr;
      end
      @(negedge clk);
    end
    clear_count = 1'b0;

    s         = model_score();
    exp_pulse = 1'b0;
    if (m_armed && s >= hi_v) begin
      exp_pulse = 1'b1;
      m_armed   = 1'b0;
      if (m_cnt < CNT_MAX) begin
        m_cnt++;
        if (m_cnt == CNT_MAX) m_sat = 1'b1;
      end
    end else if (!m_armed && s < lo_v) begin
      m_armed = 1'b1;
    end
    if (clr) begin
      m_cnt = 0;
      m_sat = 1'b0;
    end
    check("score", score, s);
    check("step_pulse", step_pulse, exp_pulse);
    check("step_count", step_count, m_cnt);
    check("count_sat", count_sat, m_sat);
    check("ready_after", sample_ready, 1);
  endtask

  task automatic plain_sample(input int ax, input int ay);
    send_sample(ax, ay, 1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; sample_valid = 1'b0; sample = '0; clear_count = 1'b0;
    wr_en1 = 1'b0; wr_addr1 = '0; wr_data1 = '0;
    wr_en2 = 1'b0; wr_addr2 = '0; wr_data2 = '0;
    model_reset();
    set_thr(100, 50);
    #2;
    check("rst_ready", sample_ready, 0);
    check("rst_score", score, 0);
    check("rst_count", step_count, 0);
    check("rst_pulse", step_pulse, 0);
    check("rst_sat", count_sat, 0);
    check("rst_wr_err", wr_err, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_release", sample_ready, 1);

    // Basic detection and hysteresis with a single unit tap.
    write_weights(1'b1, 0, 1, 1'b0, 0, 0);
    plain_sample(60, -50);
    check("basic_score_110", score, 110);
    plain_sample(60, 0);
    plain_sample(10, 10);
    plain_sample(100, 20);
    check("hyst_count_2", step_count, 2);

    // Port collision, busy write rejection and write-at-acceptance.
    write_weights(1'b1, 3, 5, 1'b1, 3, 9);
    plain_sample(0, 0);
    send_sample(5, 5, 1'b0, 3, -7, 1'b1, 1'b0);
    plain_sample(7, -3);
    send_sample(-20, 30, 1'b1, 1, 4, 1'b0, 1'b0);

    // Reset in the middle of MAC.
    sample = {DATA_W'(12), DATA_W'(34)};
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_rst_ready", sample_ready, 0);
    check("mid_rst_score", score, 0);
    check("mid_rst_count", step_count, 0);
    check("mid_rst_pulse", step_pulse, 0);
    check("mid_rst_sat", count_sat, 0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    check("mid_rst_ready_release", sample_ready, 1);
    plain_sample(100, 20);
    write_weights(1'b1, 0, 1, 1'b0, 0, 0);
    plain_sample(100, 20);

    // Counter saturation, then clear racing a step.
    set_thr(100, 50);
    for (int i = 0; i < 34; i++) begin
      if (i % 2 == 0) plain_sample(100, 100);
      else            plain_sample(0, 0);
    end
    check("sat_count_15", step_count, 15);
    check("sat_flag", count_sat, 1);
    send_sample(100, 100, 1'b0, 0, 0, 1'b0, 1'b1);
    check("clear_beats_inc", step_count, 0);

    // Accumulator clamp with every tap at the positive limit.
    for (int i = 0; i < NW; i += 2) write_weights(1'b1, i, 127, 1'b1, i + 1, 127);
    for (int i = 0; i < NW; i++) plain_sample(-128, -128);
    check("clamp_32767", score, 32767);

    // Randomised traffic.
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0)
        write_weights(1'b1, int'($urandom_range(0, NW - 1)), int'($urandom_range(0, 255)) - 128,
                      $urandom_range(0, 1) == 1, int'($urandom_range(0, NW - 1)),
                      int'($urandom_range(0, 31)) - 16);
      if ($urandom_range(0, 4) == 0)
        set_thr(int'($urandom_range(0, 40000)) - 20000, int'($urandom_range(0, 40000)) - 20000);
      send_sample(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                  $urandom_range(0, 5) == 0, int'($urandom_range(0, NW - 1)),
                  int'($urandom_range(0, 255)) - 128,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
